// File: rtl/mul_shift_add32_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_shift_add32_if
//  Description : Start/busy operand and result bundle for the shift-add multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_shift_add32_if;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        a_signed;
    logic        b_signed;
    logic        start;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        busy;

    modport master (
        output a_in, b_in, a_signed, b_signed, start,
        input  p_hi, p_lo, busy
    );

    modport slave (
        input  a_in, b_in, a_signed, b_signed, start,
        output p_hi, p_lo, busy
    );
endinterface
`default_nettype wire

// File: rtl/mul_shift_add32.sv
`default_nettype none
// ============================================================================
//  Module      : mul_shift_add32
//  Description : Sequential 32x32 shift-add multiplier, 64-bit signed/unsigned product.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_shift_add32 (
    input  wire logic         clk,
    input  wire logic         rstLow,
    mul_shift_add32_if.slave  bus
);

    typedef enum logic [1:0] {
        S_PREP   = 2'd0,
        S_LOOP   = 2'd1,
        S_SIGN   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_count;
    logic [31:0] r_mcand;
    logic [32:0] r_hi;
    logic [31:0] r_lo;
    logic        r_neg;

    logic        w_sa;
    logic        w_sb;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [63:0] w_neg_prod;

    // Magnitudes: negating 0x80000000 wraps back to 0x80000000, which is the
    // correct unsigned magnitude.
    assign w_sa       = bus.a_signed & bus.a_in[31];
    assign w_sb       = bus.b_signed & bus.b_in[31];
    assign w_a_mag    = w_sa ? (32'd0 - bus.a_in) : bus.a_in;
    assign w_b_mag    = w_sb ? (32'd0 - bus.b_in) : bus.b_in;
    assign w_sum      = r_lo[0] ? (r_hi + {1'b0, r_mcand}) : r_hi;
    assign w_neg_prod = 64'd0 - {r_hi[31:0], r_lo};

    assign bus.p_hi = r_hi[31:0];
    assign bus.p_lo = r_lo;

    always_ff @(posedge clk) begin
        if (!rstLow) begin
            r_state <= S_FINISH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus.busy     = 1'b1;
        unique case (r_state)
            S_PREP:   w_next_state = S_LOOP;
            S_LOOP:   if (r_count == c_LAST_ITER) w_next_state = S_SIGN;
            S_SIGN:   w_next_state = S_FINISH;
            S_FINISH: begin
                bus.busy = 1'b0;
                if (bus.start) w_next_state = S_PREP;
            end
            default:  w_next_state = S_FINISH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstLow) begin
            r_count <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg   <= 1'b0;
        end else begin
            unique case (r_state)
                S_PREP: begin
                    r_mcand <= w_a_mag;
                    r_lo    <= w_b_mag;
                    r_hi    <= '0;
                    r_neg   <= w_sa ^ w_sb;
                    r_count <= '0;
                end
                S_LOOP: begin
                    // Conditional add, then shift {hi,lo} right by one.
                    r_hi    <= {1'b0, w_sum[32:1]};
                    r_lo    <= {w_sum[0], r_lo[31:1]};
                    r_count <= r_count + 5'd1;
                end
                S_SIGN: begin
                    if (r_neg) begin
                        r_hi <= {1'b0, w_neg_prod[63:32]};
                        r_lo <= w_neg_prod[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_shift_add32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_shift_add32
//  Description : Self-checking bench for mul_shift_add32 against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_shift_add32;

    logic clk;
    logic rstLow;
    int   n_checks;
    int   n_errors;

    mul_shift_add32_if bus ();

    mul_shift_add32 dut (
        .clk    (clk),
        .rstLow (rstLow),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Sign-extend or zero-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] gen_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input bit disturb,
                          input logic [63:0] exp);
        int cnt;
        @(negedge clk);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.a_signed = sa;
        bus.b_signed = sb;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (disturb) begin
                bus.start = (cnt == 5 || cnt == 20);
                if (cnt >= 2) begin
                    bus.a_in     = $urandom;
                    bus.b_in     = $urandom;
                    bus.a_signed = 1'($urandom);
                    bus.b_signed = 1'($urandom);
                end
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(cnt), 64'd34);
        check(tag, {bus.p_hi, bus.p_lo}, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsa;
        logic        rsb;
        n_checks     = 0;
        n_errors     = 0;
        rstLow       = 1'b0;
        bus.start    = 1'b1;
        bus.a_in     = 32'd0;
        bus.b_in     = 32'd0;
        bus.a_signed = 1'b0;
        bus.b_signed = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_prod", {bus.p_hi, bus.p_lo}, 64'd0);
        rstLow    = 1'b1;
        bus.start = 1'b0;

        run_op("mulhu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFE_00000001);
        run_op("s7xm3",     32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFEB);
        run_op("minxmin",   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 64'h40000000_00000000);
        run_op("mulhsu",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF_00000001);
        run_op("zero_neg",  32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 64'd0);

        // Mid-operation start pulses and operand changes must not disturb the result.
        run_op("disturb", 32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0, 1'b1,
               ref_mul(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0));
        repeat (100) @(negedge clk);
        check("hold_busy", 64'(bus.busy), 64'd0);
        check("hold_prod", {bus.p_hi, bus.p_lo},
              ref_mul(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0));

        for (int i = 0; i < 24; i++) begin
            ra  = gen_operand();
            rb  = gen_operand();
            rsa = 1'($urandom);
            rsb = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rsa, rsb, 1'b0, ref_mul(ra, rb, rsa, rsb));
        end

        // Abort: reset lands on E15 of an operation.
        @(negedge clk);
        bus.a_in     = 32'hFFFF_0001;
        bus.b_in     = 32'h0001_FFFF;
        bus.a_signed = 1'b0;
        bus.b_signed = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_busy_pre", 64'(bus.busy), 64'd1);
        rstLow = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_prod", {bus.p_hi, bus.p_lo}, 64'd0);
        rstLow = 1'b1;
        run_op("post_abort", 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 64'h00000000_0000000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
